ula_seq: RTL

- Sequential 4-bit ULA (ALU) for the microcore, directly downstream of the control FSM.
- Accepts an operation when the FSM raises ena_ula in its Arit/Logica states, then executes it in one cycle, or in four cycles for multiply.
- Returns a one-cycle ula_ack that lets the FSM advance to its write-back state.
- Holds result and flags stable for the write-back path until the next operation is captured.

---
 rtl/ula_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ula_seq.sv
// ula_seq: sequential 4-bit ALU with one-cycle ops, shift-add multiply and ack handshake
module ula_seq #(
   parameter int W       = 4,
   parameter int MUL_CYC = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena_ula,
   input  logic [1:0]   mnm_in,
   input  logic [1:0]   func_in,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   output logic         ula_ack,
   output logic [W-1:0] result,
   output logic         flag_z,
   output logic         flag_c,
   output logic         flag_n,
   output logic         flag_v,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, EXEC, ACK, RELEASE} state_t;
   localparam int CW = $clog2(MUL_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYC - 1);
   state_t         state, state_nxt;
   logic [1:0]     mnm_r, func_r;
   logic [W-1:0]   a_r, b_r, val;
   logic [2*W-1:0] acc, acc_nxt;
   logic [CW-1:0]  cnt;
   logic [W:0]     sum, diff;
   logic           is_mul, done, c_n, v_n, keep;
   assign is_mul  = (mnm_r == 2'b10) && (func_r == 2'b10);
   assign done    = !is_mul || (cnt == CNT_LAST);
   assign sum     = {1'b0, a_r} + {1'b0, b_r};
   assign diff    = {1'b0, a_r} - {1'b0, b_r};
   assign acc_nxt = acc + (({{W{1'b0}}, a_r} << cnt) & {(2*W){b_r[cnt]}});
   assign ula_ack = (state == ACK);
   assign busy    = (state != IDLE);
   // state register; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end
   // handshake sequencing: capture, execute, ack, wait for request release
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = ena_ula ? EXEC : IDLE;
         EXEC:    state_nxt = done ? ACK : EXEC;
         ACK:     state_nxt = RELEASE;
         RELEASE: state_nxt = ena_ula ? RELEASE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   // new value and carry/overflow for the captured operation; C and V default to held
   always_comb begin
      val  = b_r;
      c_n  = flag_c;
      v_n  = flag_v;
      keep = 1'b0;
      case ({mnm_r, func_r})
         4'b0100: val = a_r & b_r;
         4'b0101: val = a_r | b_r;
         4'b0110: val = a_r ^ b_r;
         4'b0111: val = ~a_r;
         4'b1000: begin
            val = sum[W-1:0];
            c_n = sum[W];
            v_n = (a_r[W-1] == b_r[W-1]) && (sum[W-1] != a_r[W-1]);
         end
         4'b1001, 4'b1011: begin
            val  = diff[W-1:0];
            c_n  = diff[W];
            v_n  = (a_r[W-1] != b_r[W-1]) && (diff[W-1] != a_r[W-1]);
            keep = func_r[0] & func_r[1];
         end
         4'b1010: begin
            val = acc_nxt[W-1:0];
            c_n = |acc_nxt[2*W-1:W];
            v_n = 1'b0;
         end
         4'b1100: begin val = {a_r[W-2:0], 1'b0};     c_n = a_r[W-1]; end
         4'b1101: begin val = {1'b0, a_r[W-1:1]};     c_n = a_r[0];   end
         4'b1110: begin val = {a_r[W-2:0], a_r[W-1]}; c_n = a_r[W-1]; end
         4'b1111: begin val = {a_r[0], a_r[W-1:1]};   c_n = a_r[0];   end
         default: val = b_r;
      endcase
   end
   // operand capture, multiply accumulation and result/flag write-back at end of EXEC
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mnm_r  <= '0;
         func_r <= '0;
         a_r    <= '0;
         b_r    <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         flag_n <= 1'b0;
         flag_v <= 1'b0;
      end else if (state == IDLE && ena_ula) begin
         mnm_r  <= mnm_in;
         func_r <= func_in;
         a_r    <= op_a;
         b_r    <= op_b;
         acc    <= '0;
         cnt    <= '0;
      end else if (state == EXEC) begin
         if (is_mul) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
         end
         if (done) begin
            if (!keep) result <= val;
            flag_z <= (val == '0);
            flag_n <= val[W-1];
            flag_c <= c_n;
            flag_v <= v_n;
         end
      end
   end
endmodule
